// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_ctrl
// Description : Frequency-select controller for the programmable clock
//               divider. Changes the 2-bit ratio select only on a rising
//               edge of the divider output, with a manual req/ack handshake
//               and an automatic sweep mode with programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl #(
  parameter int DWELL_W = 8,
  parameter int TMO     = 64
) (
  input  logic               clkin_i,
  input  logic               reset_ni,
  input  logic               mode_i,
  input  logic               req_i,
  input  logic [1:0]         req_freq_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               clkout_i,
  output logic [1:0]         freq_o,
  output logic               ack_o,
  output logic               busy_o,
  output logic               step_o,
  output logic               tmo_err_o
);

  localparam int                TMO_W    = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_HOLD_ACK  = 2'd2,
    ST_SWEEP     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           freq_q, freq_d;
  logic [1:0]           pend_q, pend_d;
  logic [DWELL_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                 step_q, step_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 clkout_q;

  logic                 w_rise;
  logic [DWELL_W-1:0]   w_dwell_eff;
  logic [DWELL_W:0]     w_edge_inc;
  logic                 w_dwell_reached;

  // clkout is already in the clkin domain, so a single register suffices
  // for edge detection.
  assign w_rise          = clkout_i & ~clkout_q;
  // A dwell of zero behaves as one edge per step.
  assign w_dwell_eff     = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
  // Compare with one extra bit so the increment cannot wrap; >= handles a
  // dwell lowered below the current count.
  assign w_edge_inc      = {1'b0, edge_cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign w_dwell_reached = (w_edge_inc >= {1'b0, w_dwell_eff});

  // Next-state and datapath update for the mode/handshake controller.
  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    pend_d     = pend_q;
    edge_cnt_d = edge_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    step_d     = 1'b0;
    tmo_err_d  = tmo_err_q;

    case (state_q)
      ST_IDLE: begin
        if (mode_i) begin
          state_d    = ST_SWEEP;
          edge_cnt_d = '0;
        end else if (req_i) begin
          pend_d    = req_freq_i;
          tmo_err_d = 1'b0;
          if (req_freq_i == freq_q) begin
            state_d = ST_HOLD_ACK;
          end else begin
            state_d   = ST_WAIT_EDGE;
            tmo_cnt_d = '0;
          end
        end
      end

      ST_WAIT_EDGE: begin
        // mode and req are deliberately ignored until the change lands.
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (w_rise || (tmo_cnt_q == TMO_LAST)) begin
          freq_d  = pend_q;
          state_d = ST_HOLD_ACK;
          if (!w_rise) begin
            tmo_err_d = 1'b1;
          end
        end
      end

      ST_HOLD_ACK: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        if (!mode_i) begin
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
        end else if (w_rise) begin
          if (w_dwell_reached) begin
            freq_d     = freq_q + 2'd1;
            step_d     = 1'b1;
            edge_cnt_d = '0;
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any pending change.
  always_ff @(posedge clkin_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      freq_q     <= 2'b00;
      pend_q     <= 2'b00;
      edge_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      step_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      clkout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      pend_q     <= pend_d;
      edge_cnt_q <= edge_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      step_q     <= step_d;
      tmo_err_q  <= tmo_err_d;
      clkout_q   <= clkout_i;
    end
  end

  assign freq_o    = freq_q;
  assign ack_o     = (state_q == ST_HOLD_ACK);
  assign busy_o    = (state_q == ST_WAIT_EDGE);
  assign step_o    = step_q;
  assign tmo_err_o = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_ctrl
// Description : Directed scoreboard bench for clkdiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;

  localparam int DWELL_W = 8;
  localparam int TMO     = 64;

  logic               clk;
  logic               reset_n;
  logic               mode;
  logic               req;
  logic [1:0]         req_freq;
  logic [DWELL_W-1:0] dwell;
  logic               clkout;
  logic [1:0]         freq;
  logic               ack;
  logic               busy;
  logic               step;
  logic               tmo_err;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [1:0] mfreq;

  clkdiv_ctrl #(.DWELL_W(DWELL_W), .TMO(TMO)) dut (
    .clkin_i    (clk),
    .reset_ni   (reset_n),
    .mode_i     (mode),
    .req_i      (req),
    .req_freq_i (req_freq),
    .dwell_i    (dwell),
    .clkout_i   (clkout),
    .freq_o     (freq),
    .ack_o      (ack),
    .busy_o     (busy),
    .step_o     (step),
    .tmo_err_o  (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed status word: {2'b0, freq, ack, busy, step, tmo_err}.
  function automatic logic [7:0] pk(input logic [1:0] f, input logic a,
                                    input logic b, input logic s,
                                    input logic t);
    return {2'b00, f, a, b, s, t};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [7:0] st();
    return pk(freq, ack, busy, step, tmo_err);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    mode     = 1'b0;
    req      = 1'b0;
    req_freq = 2'b00;
    dwell    = 8'd3;
    clkout   = 1'b0;

    // Reset state, then idle.
    cyc(2);
    push("reset_state", pk(2'b00, 0, 0, 0, 0)); chk(st());
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      push("idle_hold", pk(2'b00, 0, 0, 0, 0)); chk(st());
    end

    // Manual change to 10 via a clkout rise.
    req = 1'b1; req_freq = 2'b10;
    cyc(1);
    push("man_busy", pk(2'b00, 0, 1, 0, 0)); chk(st());
    req = 1'b0;  // early drop: change must still complete
    cyc(2);
    push("man_busy_wait", pk(2'b00, 0, 1, 0, 0)); chk(st());
    req = 1'b1;
    clkout = 1'b1;
    cyc(1);
    push("man_done", pk(2'b10, 1, 0, 0, 0)); chk(st());
    cyc(1);
    push("man_hold_ack", pk(2'b10, 1, 0, 0, 0)); chk(st());
    req = 1'b0; clkout = 1'b0;
    cyc(1);
    push("man_ack_drop", pk(2'b10, 0, 0, 0, 0)); chk(st());

    // Same-ratio request.
    req = 1'b1; req_freq = 2'b10;
    cyc(1);
    push("same_ack", pk(2'b10, 1, 0, 0, 0)); chk(st());
    req = 1'b0;
    cyc(1);
    push("same_release", pk(2'b10, 0, 0, 0, 0)); chk(st());

    // Timeout with clkout held low.
    req = 1'b1; req_freq = 2'b11;
    cyc(1);
    push("tmo_accept", pk(2'b10, 0, 1, 0, 0)); chk(st());
    cyc(TMO - 1);
    push("tmo_edge_minus1", pk(2'b10, 0, 1, 0, 0)); chk(st());
    cyc(1);
    push("tmo_forced", pk(2'b11, 1, 0, 0, 1)); chk(st());
    req = 1'b0;
    cyc(1);
    push("tmo_err_sticky", pk(2'b11, 0, 0, 0, 1)); chk(st());
    req = 1'b1; req_freq = 2'b11;
    cyc(1);
    push("tmo_err_clear", pk(2'b11, 1, 0, 0, 0)); chk(st());
    req = 1'b0;
    cyc(1);

    // Return to 00, with rise and timeout boundary untouched.
    req = 1'b1; req_freq = 2'b00;
    cyc(1);
    clkout = 1'b1;
    cyc(1);
    push("to_00", pk(2'b00, 1, 0, 0, 0)); chk(st());
    req = 1'b0; clkout = 1'b0;
    cyc(1);

    // Sweep, dwell=3 then dwell=0.
    mode = 1'b1; dwell = 8'd3;
    cyc(1);
    mfreq = 2'b00;
    for (int i = 1; i <= 15; i++) begin
      if (i == 13) dwell = 8'd0;
      clkout = 1'b1;
      cyc(1);
      if ((i <= 12 && (i % 3) == 0) || i > 12) begin
        mfreq = mfreq + 2'd1;
        push("sweep_step", pk(mfreq, 0, 0, 1, 0));
      end else begin
        push("sweep_nostep", pk(mfreq, 0, 0, 0, 0));
      end
      chk(st());
      clkout = 1'b0;
      cyc(1);
      push("sweep_step_low", pk(mfreq, 0, 0, 0, 0)); chk(st());
    end

    // Manual change started, then mode=1 during WAIT_EDGE.
    mode = 1'b0;
    cyc(1);
    req = 1'b1; req_freq = mfreq + 2'd2;
    cyc(1);
    push("mode_wait_busy", pk(mfreq, 0, 1, 0, 0)); chk(st());
    mode = 1'b1;
    cyc(2);
    push("mode_ignored", pk(mfreq, 0, 1, 0, 0)); chk(st());
    clkout = 1'b1;
    cyc(1);
    mfreq = mfreq + 2'd2;
    push("mode_change_done", pk(mfreq, 1, 0, 0, 0)); chk(st());
    req = 1'b0; clkout = 1'b0;
    cyc(2);
    push("mode_to_sweep", pk(mfreq, 0, 0, 0, 0)); chk(st());
    clkout = 1'b1;
    cyc(1);
    mfreq = mfreq + 2'd1;
    push("sweep_after_manual", pk(mfreq, 0, 0, 1, 0)); chk(st());

    // Asynchronous reset while in SWEEP.
    #1 reset_n = 1'b0;
    #1;
    push("async_reset", pk(2'b00, 0, 0, 0, 0)); chk(st());
    cyc(1);
    reset_n = 1'b1; clkout = 1'b0; mode = 1'b0;
    cyc(2);
    push("post_reset_idle", pk(2'b00, 0, 0, 0, 0)); chk(st());

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Frequency-select controller for the programmable clock divider. Drives the divider's 2-bit `freq` select and changes it only on a divider output boundary, a rising edge of `clkout`, so ratio changes never truncate an output period. Supports two modes: a manual request/acknowledge handshake, and an automatic sweep that steps through all four ratios with a programmable dwell. Sits between the test or control logic and the divider, in the same `clkin` domain.

## Interface
- `DWELL_W`, 8: width of the dwell value and the edge counter.
- `TMO`, 64: `clkin` cycles to wait for a `clkout` rising edge before forcing a pending change.
- `clkin`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = manual, 1 = sweep.
- `req`  in  1  manual change request, level, 4-phase.
- `req_freq`  in  2  requested ratio select; sampled when `req` is accepted.
- `dwell`  in  DWELL_W  `clkout` rising edges per sweep step; 0 is treated as 1.
- `clkout`  in  1  divider output, fed back from the divider.
- `freq`  out  2  ratio select to the divider.
- `ack`  out  1  manual handshake acknowledge.
- `busy`  out  1  high while a manual change is pending.
- `step`  out  1  one-cycle pulse on each sweep advance.
- `tmo_err`  out  1  sticky flag: a change was forced by timeout.

## Operation
- Edge detect: register `clkout` into `clkout_q`. `rise = clkout & ~clkout_q`. No synchronizer, because both are in the same domain.
- States: IDLE, WAIT_EDGE, HOLD_ACK, SWEEP.
- IDLE transitions:
  - `mode=1` → SWEEP, clearing the edge counter.
  - Otherwise, if `req=1`, latch `req_freq` into `pend`.
  - If `pend == freq`, go to HOLD_ACK with no change to `freq`.
  - Otherwise go to WAIT_EDGE and clear the timeout counter.
- WAIT_EDGE:
  - `busy=1`; the timeout counter increments every cycle.
  - On `rise`, or when the counter reaches `TMO-1`: `freq <= pend` and go to HOLD_ACK.
  - If the transition was caused by timeout without `rise`, set `tmo_err`.
  - `mode` is ignored until the pending change completes.
  - If `req` drops early, the change still completes.
- HOLD_ACK:
  - `ack=1`, `busy=0`.
  - Stay until `req=0`, then return to IDLE with `ack=0` on the following cycle.
- SWEEP:
  - Each `rise` increments the edge counter.
  - When the counter reaches `max(dwell,1)` at a `rise`: `freq <= freq+1` (wraps 11→00), pulse `step`, clear the counter.
  - `req` is ignored; `ack` stays 0.
  - `mode=0` → IDLE; `freq` holds its current value and the counter clears.
- Width rules:
  - The edge counter is `DWELL_W` bits and saturates at `dwell`.
  - The timeout counter is `$clog2(TMO)` bits.
  - Changing `dwell` mid-step takes effect immediately. If the counter is already ≥ the new `dwell`, the step occurs on the next `rise`.
- `tmo_err` clears only on reset or when a new manual request is accepted.

## Timing
- Reset (asynchronous, `reset=0`): `freq=00`, `ack=0`, `busy=0`, `step=0`, `tmo_err=0`, state IDLE, all counters 0, `clkout_q=0`.
- Request acceptance: `busy` rises the cycle after `req` is sampled high in IDLE.
- Change latency: `freq` updates on the `clkin` edge where `rise` is true, one `clkin` cycle after `clkout` goes high. `ack` rises on that same edge.
- Same-ratio request: `ack` is high one cycle after acceptance, and `freq` does not change.
- Worst-case change latency is `TMO` cycles after acceptance.
- Sweep: `freq` and `step` update on the same edge. `step` is high for exactly one `clkin` cycle.
- Simultaneous `rise` and timeout in the same cycle counts as an edge: no `tmo_err`.
- `reset` asserted mid-operation aborts any pending change. `pend` is discarded.

## Test plan
- Reset then hold: assert `reset=0` for 2 cycles, release, idle 10 cycles → `freq=00`, `ack=0`, `busy=0`, `step=0`, `tmo_err=0` throughout.
- Manual change: `mode=0`, raise `req` with `req_freq=10`, toggle `clkout` → `busy` high until the first `clkout` rise; `freq=10` and `ack=1` on that rise edge; `ack` drops one cycle after `req` drops.
- Same ratio: with `freq=10`, request `req_freq=10` → `ack` high one cycle after acceptance, `busy` never high, `freq` stays 10.
- Timeout: `TMO=64`, request `req_freq=11` with `clkout` held 0 → `freq=11`, `ack=1` and `tmo_err=1` exactly 64 cycles after acceptance; the next accepted request clears `tmo_err`.
- Sweep: `mode=1`, `dwell=3`, starting from `freq=00` → `freq` sequence 01, 10, 11, 00 at every 3rd `clkout` rise, with one `step` pulse per change; `dwell=0` gives one step per rise.
- Mode and reset interaction: start a manual change, then set `mode=1` while in WAIT_EDGE → the manual change completes first. In SWEEP, pulse `reset` low → all outputs return to their reset values immediately, without waiting for a clock edge.
